// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble then MSB-first payload, one bit per clkEN strobe.
// Optional even-parity trailer bit when PARITY_TX_EN is defined.
module serial_frame_tx #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1101,
  parameter int                 DATA_W   = 8,
  parameter logic               IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEN,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              SerOut,
  output logic              SerOutValid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

`ifdef PARITY_TX_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                done_nxt, ser_nxt, pat_bit;
`ifdef PARITY_TX_EN
  logic                par_bit;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) begin
        shreg_nxt = data_in;
        cnt_nxt   = CNT_W'(PAT_LEN-1);
        state_nxt = PRE;
      end
      PRE: if (clkEN) begin
        if (cnt == '0) begin
          cnt_nxt   = CNT_W'(DATA_W-1);
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: if (clkEN) begin
        shreg_nxt = shreg << 1;
        if (cnt == '0) begin
          cnt_nxt = '0;
`ifdef PARITY_TX_EN
          state_nxt = PAR;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
`ifdef PARITY_TX_EN
      PAR: if (clkEN) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    pat_bit = 1'b0;
    for (int i = 0; i < PAT_LEN; i++)
      if (cnt_nxt == CNT_W'(i)) pat_bit = PATTERN[i];
    ser_nxt = IDLE_LVL;
    case (state_nxt)
      PRE:     ser_nxt = pat_bit;
      DATA:    ser_nxt = shreg_nxt[DATA_W-1];
`ifdef PARITY_TX_EN
      PAR:     ser_nxt = par_bit;
`endif
      default: ser_nxt = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      SerOut      <= IDLE_LVL;
      SerOutValid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      SerOut      <= ser_nxt;
      SerOutValid <= (state_nxt == DATA)
`ifdef PARITY_TX_EN
                     || (state_nxt == PAR)
`endif
                     ;
      busy        <= (state_nxt != IDLE);
      done        <= done_nxt;
    end
  end

`ifdef PARITY_TX_EN
  // Parity is taken at latch time since the shift register is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        par_bit <= 1'b0;
    else if (state == IDLE && start) par_bit <= ^data_in;
  end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (default parameters); parity scenario
// runs only when PARITY_TX_EN is defined.
module tb_serial_frame_tx;

  logic       clk, rst, clkEN, start;
  logic [7:0] data_in;
  logic       SerOut, SerOutValid, busy, done;

  int n_cmp = 0, n_err = 0, done_seen = 0;

`ifdef PARITY_TX_EN
  localparam int FLEN = 13;
  localparam logic [FLEN-1:0] EXP_A5  = 13'b1101_10100101_0;
  localparam logic [FLEN-1:0] EXP_3C  = 13'b1101_00111100_0;
  localparam logic [FLEN-1:0] EXP_5A  = 13'b1101_01011010_0;
  localparam logic [FLEN-1:0] EXP_07  = 13'b1101_00000111_1;
  localparam logic [FLEN-1:0] EXP_03  = 13'b1101_00000011_0;
  localparam logic [FLEN-1:0] VAL_EXP = 13'b0000_11111111_1;
`else
  localparam int FLEN = 12;
  localparam logic [FLEN-1:0] EXP_A5  = 12'b1101_10100101;
  localparam logic [FLEN-1:0] EXP_3C  = 12'b1101_00111100;
  localparam logic [FLEN-1:0] EXP_5A  = 12'b1101_01011010;
  localparam logic [FLEN-1:0] VAL_EXP = 12'b0000_11111111;
`endif

  serial_frame_tx dut (
    .clk(clk), .rst(rst), .clkEN(clkEN), .start(start), .data_in(data_in),
    .SerOut(SerOut), .SerOutValid(SerOutValid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic send_bit(output logic b, output logic v);
    b = SerOut; v = SerOutValid;
    tick; tick;
    clkEN = 1'b1; tick; clkEN = 1'b0;
  endtask

  task automatic begin_frame(input logic [7:0] d);
    data_in = d; start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic run_frame(output logic [FLEN-1:0] got, output logic [FLEN-1:0] val);
    logic b, v;
    for (int i = 0; i < FLEN; i++) begin
      send_bit(b, v);
      got[FLEN-1-i] = b; val[FLEN-1-i] = v;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clkEN = 1'b0; start = 1'b0; data_in = '0;
    tick; tick;
    rst = 1'b0; tick;
    n_cmp++;
    if ({SerOut, busy, SerOutValid, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_state: got %b required 0000", {SerOut, busy, SerOutValid, done});
    end
  endtask

  task automatic test_basic_frame;
    logic [FLEN-1:0] got, val;
    logic b, v;
    int d0;
    begin_frame(8'hA5);
    data_in = 8'h00;
    n_cmp++;
    if (busy !== 1'b1 || SerOut !== 1'b1) begin
      n_err++; $display("FAIL start_latency: busy=%b SerOut=%b required 1 1", busy, SerOut);
    end
    d0 = done_seen;
    for (int i = 0; i < FLEN; i++) begin
      send_bit(b, v);
      got[FLEN-1-i] = b; val[FLEN-1-i] = v;
      if (i == FLEN-2) begin
        n_cmp++;
        if (done_seen != d0) begin
          n_err++; $display("FAIL early_done: done pulses %0d required 0", done_seen - d0);
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_edge: done=%b busy=%b required 1 0", done, busy);
    end
    tick;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_width: done=%b required 0", done);
    end
    n_cmp++;
    if (got !== EXP_A5) begin
      n_err++; $display("FAIL basic_bits: got %b required %b", got, EXP_A5);
    end
    n_cmp++;
    if (val !== VAL_EXP) begin
      n_err++; $display("FAIL basic_valid: got %b required %b", val, VAL_EXP);
    end
  endtask

  task automatic test_strobe_gating;
    logic [FLEN-1:0] got, val;
    logic b, v, s;
    int changes;
    begin_frame(8'h3C);
    for (int i = 0; i < FLEN; i++) begin
      if (i == 7) begin
        s = SerOut; changes = 0;
        for (int k = 0; k < 20; k++) begin
          tick;
          if (SerOut !== s || SerOutValid !== 1'b1) changes++;
        end
        n_cmp++;
        if (changes != 0) begin
          n_err++; $display("FAIL gate_hold: %0d changes while clkEN low, required 0", changes);
        end
      end
      send_bit(b, v);
      got[FLEN-1-i] = b; val[FLEN-1-i] = v;
    end
    tick;
    n_cmp++;
    if (got !== EXP_3C) begin
      n_err++; $display("FAIL gate_bits: got %b required %b", got, EXP_3C);
    end
  endtask

  task automatic test_start_ignored;
    logic [FLEN-1:0] got, val;
    logic b, v;
    int d0;
    d0 = done_seen;
    begin_frame(8'hA5);
    for (int i = 0; i < FLEN; i++) begin
      if (i == 6) begin
        data_in = 8'h00; start = 1'b1;
        tick; tick; tick;
        start = 1'b0;
      end
      send_bit(b, v);
      got[FLEN-1-i] = b; val[FLEN-1-i] = v;
    end
    tick; tick;
    n_cmp++;
    if (got !== EXP_A5) begin
      n_err++; $display("FAIL start_ignored_bits: got %b required %b", got, EXP_A5);
    end
    n_cmp++;
    if (busy !== 1'b0 || done_seen - d0 != 1) begin
      n_err++; $display("FAIL start_no_queue: busy=%b done pulses=%0d required 0 1", busy, done_seen - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic [FLEN-1:0] got, val;
    data_in = 8'h5A; start = 1'b1; tick;
    run_frame(got, val);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: done=%b busy=%b required 1 0", done, busy);
    end
    tick;
    n_cmp++;
    if (busy !== 1'b1 || SerOut !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_restart: busy=%b SerOut=%b done=%b required 1 1 0", busy, SerOut, done);
    end
    start = 1'b0; data_in = 8'hFF;
    run_frame(got, val);
    tick;
    n_cmp++;
    if (got !== EXP_5A) begin
      n_err++; $display("FAIL b2b_bits: got %b required %b", got, EXP_5A);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [FLEN-1:0] got, val;
    logic b, v;
    int d0;
    begin_frame(8'hA5);
    send_bit(b, v);
    d0 = done_seen;
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (SerOut !== 1'b0 || busy !== 1'b0 || SerOutValid !== 1'b0) begin
      n_err++; $display("FAIL rst_async: SerOut=%b busy=%b valid=%b required 0 0 0", SerOut, busy, SerOutValid);
    end
    tick; tick;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clkEN = 1'b1; tick; clkEN = 1'b0; tick;
    end
    n_cmp++;
    if (done_seen != d0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_no_done: done pulses=%0d busy=%b required 0 0", done_seen - d0, busy);
    end
    begin_frame(8'hA5);
    run_frame(got, val);
    tick;
    n_cmp++;
    if (got !== EXP_A5) begin
      n_err++; $display("FAIL rst_recover: got %b required %b", got, EXP_A5);
    end
  endtask

`ifdef PARITY_TX_EN
  task automatic test_parity;
    logic [FLEN-1:0] got, val;
    begin_frame(8'h07);
    run_frame(got, val);
    tick;
    n_cmp++;
    if (got !== EXP_07 || val[0] !== 1'b1) begin
      n_err++; $display("FAIL parity_07: got %b valid %b required %b valid 1", got, val[0], EXP_07);
    end
    begin_frame(8'h03);
    run_frame(got, val);
    tick;
    n_cmp++;
    if (got !== EXP_03 || val[0] !== 1'b1) begin
      n_err++; $display("FAIL parity_03: got %b valid %b required %b valid 1", got, val[0], EXP_03);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic_frame;
    test_strobe_gating;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef PARITY_TX_EN
    test_parity;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: the sending end of the sequence-detector link. On a start request it latches a parallel payload and shifts out a fixed preamble pattern, then the payload, one bit per `clkEN` strobe on `SerOut`. The receiving sequence detector uses the preamble to frame the payload, so the bench and board can drive it without hand-timed `SerIn` stimulus.

## Interface
Parameters:
- `PAT_LEN`, 4: preamble length in bits (2..8).
- `PATTERN`, 4'b1101: preamble bits, sent MSB first.
- `DATA_W`, 8: payload width in bits (1..16).
- `IDLE_LVL`, 1'b0: `SerOut` level when not transmitting.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clkEN` in 1: bit strobe; advances one bit per rising edge where it is high.
- `start` in 1: frame request, level-sampled in IDLE.
- `data_in` in `DATA_W`: payload, latched when `start` is accepted.
- `SerOut` out 1: serial line.
- `SerOutValid` out 1: high while `SerOut` carries a payload bit (or parity bit).
- `busy` out 1: high from start acceptance until the frame ends.
- `done` out 1: one-cycle pulse after the last bit is consumed.

## Operation
- **States:** IDLE, PRE, DATA, PAR (only when PARITY_TX_EN is defined).
- **IDLE:**
  - `SerOut`=`IDLE_LVL`; `SerOutValid`=0; `busy`=0.
  - `start`=1 at an edge: latch `data_in` into the shift register, load bit counter = `PAT_LEN`-1, go to PRE.
  - `clkEN` is ignored on that edge.
- **PRE:**
  - `SerOut`=`PATTERN[cnt]`.
  - Each `clkEN` edge decrements `cnt`.
  - At `cnt`=0 with `clkEN`: load `cnt`=`DATA_W`-1, go to DATA.
- **DATA:**
  - `SerOut`=`shreg[DATA_W-1]` (MSB first); `SerOutValid`=1.
  - Each `clkEN` edge shifts left by 1 and decrements `cnt`.
  - At `cnt`=0 with `clkEN`: go to PAR if enabled, else IDLE with `done`=1.
- **PAR:**
  - `SerOut`=even parity of the latched payload; `SerOutValid`=1.
  - Next `clkEN` edge: go to IDLE with `done`=1.
- **Start handling:** `start` while `busy` is ignored; there is no queueing. `start` held high across the `done` cycle begins a new frame on the edge after `done` (back-to-back framing allowed).
- **Payload stability:** `data_in` changes after acceptance do not affect the frame in flight.
- **Bit counter:** width `$clog2(max(PAT_LEN,DATA_W))`. No wrap is ever observed; the counter is reloaded on every state entry.
- **Outputs:** all outputs are registered; `SerOut` has no combinational path from inputs.

## Timing
- **Reset value:** state=IDLE, `SerOut`=`IDLE_LVL`, `SerOutValid`=0, `busy`=0, `done`=0, shift register and counter = 0.
- **Reset mid-frame:** takes effect immediately (asynchronous) and aborts the frame. No `done` is issued.
- **Start latency:** `start` sampled at edge N gives `busy`=1 and `SerOut`=`PATTERN[PAT_LEN-1]` after edge N.
- **Bit hold:** each bit is held until the first subsequent edge with `clkEN`=1. With `clkEN` stuck low, the line holds indefinitely.
- **Frame length:** `PAT_LEN`+`DATA_W` (+1 with parity) `clkEN` edges. `done` goes high after the final `clkEN` edge and lasts exactly one cycle; `busy` falls on that same edge.
- **Strobe spacing:** `clkEN` high on consecutive cycles advances one bit per cycle; there is no minimum spacing.

## Configuration
- `PARITY_TX_EN` defined:
  - Adds the PAR state; one even-parity bit follows the payload, with `SerOutValid`=1.
  - Frame length becomes `PAT_LEN`+`DATA_W`+1.
- Undefined:
  - No PAR state and no parity logic.
  - Frame length is `PAT_LEN`+`DATA_W`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then 0 → `SerOut`=0, `busy`=0, `SerOutValid`=0, `done`=0.
- **Basic frame (defaults, parity off):** `data_in`=8'hA5, `start` pulse, `clkEN` every 3rd cycle → `SerOut` sequence is 1,1,0,1 then 1,0,1,0,0,1,0,1. `SerOutValid`=1 only on the last 8 bits. `done` pulses once after the 12th strobe.
- **Strobe gating:** `clkEN` held low 20 cycles mid-payload → `SerOut` and `cnt` are frozen. Resuming strobes completes the frame with no bit lost or duplicated.
- **Start rules:**
  - `start` re-asserted during DATA with `data_in`=8'h00 → ignored; the frame stays 8'hA5.
  - `start` held through `done` → a second preamble begins the next cycle.
- **Reset mid-frame:** `rst` asserted during PRE bit 2 → `SerOut`=`IDLE_LVL` and `busy`=0 at once, with no `done`.
- **Parity build (`PARITY_TX_EN`):** `data_in`=8'h07 → 13th bit is 1 with `SerOutValid`=1. `data_in`=8'h03 → 13th bit is 0.
